boot_loader: RTL

- Program loader upstream of the multicycle RISC-V processing unit.
- Accepts a byte stream (valid/ready), checks the length header, and assembles little-endian 32-bit words.
- Writes words sequentially into instruction memory, then verifies a trailing XOR checksum.
- Holds the processor in reset while loading; releases it only after a successful load.

---
 rtl/boot_loader.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/boot_loader.sv
// Purpose: program loader; length header, LE word assembly, imem writes, XOR checksum.
// Latency: 1 byte/cycle; one WRITE stall cycle per word; Done the cycle after checksum.
// Backpressure: InReady low in WRITE, DONE and ERR; a byte offered then stays pending.
//
// Ports:
//   Clk, Reset (async active-low), Start (restart pulse from DONE/ERR)
//   InValid/InData/InReady : byte stream handshake
//   IMemWAddr/IMemWData/IMemWr : instruction memory write port
//   CpuHold : holds the processor in reset until a good load completes
//   Done/Error : load outcome; WordCount : words written in the current load
module boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        InValid,
    input  logic [7:0]  InData,
    output logic        InReady,
    output logic [31:0] IMemWAddr,
    output logic [31:0] IMemWData,
    output logic        IMemWr,
    output logic        CpuHold,
    output logic        Done,
    output logic        Error,
    output logic [31:0] WordCount
);

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        DATA  = 3'd1,
        WRITE = 3'd2,
        CHK   = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t      state;
    state_t      stateNext;

    logic [1:0]  byteIdx;
    logic [31:0] lenReg;
    logic [31:0] wordReg;
    logic [31:0] addrReg;
    logic [31:0] wordCnt;
    logic [7:0]  acc;

    logic        fire;
    logic        restart;
    logic [31:0] hdrLen;

    assign fire    = InValid && InReady;
    assign restart = Start && ((state == DONE) || (state == ERR));
    // Complete length as seen while the 4th header byte is on the bus.
    assign hdrLen  = {InData, lenReg[23:0]};

    assign IMemWAddr = addrReg;
    assign IMemWData = wordReg;
    assign WordCount = wordCnt;

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= HDR;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and Moore outputs
    always_comb begin
        stateNext = state;
        InReady   = 1'b0;
        IMemWr    = 1'b0;
        CpuHold   = 1'b1;
        Done      = 1'b0;
        Error     = 1'b0;
        case (state)
            HDR: begin
                InReady = 1'b1;
                if (fire && (byteIdx == 2'd3)) begin
                    if (hdrLen == 32'd0) begin
                        stateNext = CHK;
                    end else if (hdrLen > 32'(MAX_WORDS)) begin
                        stateNext = ERR;
                    end else begin
                        stateNext = DATA;
                    end
                end
            end
            DATA: begin
                InReady = 1'b1;
                if (fire && (byteIdx == 2'd3)) begin
                    stateNext = WRITE;
                end
            end
            WRITE: begin
                IMemWr = 1'b1;
                // wordCnt increments at the end of this cycle, so compare the new value.
                if ((wordCnt + 32'd1) == lenReg) begin
                    stateNext = CHK;
                end else begin
                    stateNext = DATA;
                end
            end
            CHK: begin
                InReady = 1'b1;
                if (fire) begin
                    stateNext = (InData == acc) ? DONE : ERR;
                end
            end
            DONE: begin
                CpuHold = 1'b0;
                Done    = 1'b1;
                if (Start) begin
                    stateNext = HDR;
                end
            end
            ERR: begin
                Error = 1'b1;
                if (Start) begin
                    stateNext = HDR;
                end
            end
            default: begin
                stateNext = HDR;
            end
        endcase
    end

    // Datapath: header/word assembly, checksum, address and word counter
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            byteIdx <= 2'd0;
            lenReg  <= 32'd0;
            wordReg <= 32'd0;
            addrReg <= BASE_ADDR;
            wordCnt <= 32'd0;
            acc     <= 8'd0;
        end else if (restart) begin
            byteIdx <= 2'd0;
            lenReg  <= 32'd0;
            wordReg <= 32'd0;
            addrReg <= BASE_ADDR;
            wordCnt <= 32'd0;
            acc     <= 8'd0;
        end else begin
            if (fire) begin
                // The checksum byte is compared, never folded in.
                if (state != CHK) begin
                    acc <= acc ^ InData;
                end
                if (state == HDR) begin
                    lenReg[{byteIdx, 3'b000} +: 8] <= InData;
                end
                if (state == DATA) begin
                    wordReg[{byteIdx, 3'b000} +: 8] <= InData;
                    // Address latched as the word completes; it then persists
                    // through later states so DONE shows the last address written.
                    if (byteIdx == 2'd3) begin
                        addrReg <= BASE_ADDR + (wordCnt << 2);
                    end
                end
                if ((state == HDR) || (state == DATA)) begin
                    byteIdx <= byteIdx + 2'd1;
                end
            end
            if (state == WRITE) begin
                wordCnt <= wordCnt + 32'd1;
            end
        end
    end

endmodule
